// File: rtl/and_reduce_sequencer.sv
// Multi-cycle AND reduction: one narrow SLICE_W-input AND stage is time-shared
// over the operand, LSB slice first, with an optional early exit on the first zero slice.
module and_reduce_sequencer #(
    parameter int DATA_W     = 20,
    parameter int SLICE_W    = 4,
    parameter int EARLY_EXIT = 1,
    localparam int NSL       = (DATA_W + SLICE_W - 1) / SLICE_W,
    localparam int CNT_W     = $clog2(NSL + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_result,
    output logic [CNT_W-1:0]  out_slices,
    output logic              busy
);
    localparam int PAD_W = NSL * SLICE_W;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t             state_q, state_d;
    logic [PAD_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               res_q, res_d;
    logic [CNT_W-1:0]   slc_q, slc_d;

    logic [PAD_W-1:0]   pad_in;
    logic [SLICE_W-1:0] cur_slice;
    logic               slice_and;
    logic               finish;

    // Bits above DATA_W in the last slice read as 1 so they never affect the AND.
    always_comb begin
        pad_in             = '1;
        pad_in[DATA_W-1:0] = in_data;
    end

    assign cur_slice = data_q[int'(idx_q) * SLICE_W +: SLICE_W];
    assign slice_and = &cur_slice;
    assign finish    = (idx_q == LAST_IDX) || ((EARLY_EXIT != 0) && !slice_and);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        slc_d   = slc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = pad_in;
                    idx_d   = '0;
                    acc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                acc_d = acc_q & slice_and;
                cnt_d = cnt_q + CNT_W'(1);
                if (finish) begin
                    // Result registers are only written here, so they hold through IDLE.
                    res_d   = acc_q & slice_and;
                    slc_d   = cnt_q + CNT_W'(1);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= 1'b0;
            slc_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            slc_q   <= slc_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = res_q;
    assign out_slices = slc_q;
endmodule

// File: tb/tb_and_reduce_sequencer.sv
// Bench for and_reduce_sequencer: four parameterisations driven from one clock,
// checked against a slice-by-slice reference model of the reduction.
module tb_and_reduce_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Unit table: 0=(20,4,EE=1) 1=(20,4,EE=0) 2=(10,4,EE=1) 3=(8,8,EE=1)
    int dw_t[4] = '{20, 20, 10, 8};
    int sw_t[4] = '{4, 4, 4, 8};
    int ee_t[4] = '{1, 0, 1, 1};

    logic [3:0]  iv = '0;
    logic [3:0]  ordy = '0;
    logic [19:0] idat [4];
    logic [3:0]  ir_a, ov_a, res_a, bsy_a;
    logic [2:0]  sl_a [4];
    logic [2:0]  sl0, sl1;
    logic [1:0]  sl2;
    logic [0:0]  sl3;

    int n_chk = 0;
    int n_fail = 0;

    assign sl_a[0] = sl0;
    assign sl_a[1] = sl1;
    assign sl_a[2] = {1'b0, sl2};
    assign sl_a[3] = {2'b00, sl3};

    and_reduce_sequencer #(.DATA_W(20), .SLICE_W(4), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir_a[0]), .in_data(idat[0]),
        .out_valid(ov_a[0]), .out_ready(ordy[0]), .out_result(res_a[0]), .out_slices(sl0), .busy(bsy_a[0]));
    and_reduce_sequencer #(.DATA_W(20), .SLICE_W(4), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir_a[1]), .in_data(idat[1]),
        .out_valid(ov_a[1]), .out_ready(ordy[1]), .out_result(res_a[1]), .out_slices(sl1), .busy(bsy_a[1]));
    and_reduce_sequencer #(.DATA_W(10), .SLICE_W(4), .EARLY_EXIT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir_a[2]), .in_data(idat[2][9:0]),
        .out_valid(ov_a[2]), .out_ready(ordy[2]), .out_result(res_a[2]), .out_slices(sl2), .busy(bsy_a[2]));
    and_reduce_sequencer #(.DATA_W(8), .SLICE_W(8), .EARLY_EXIT(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir_a[3]), .in_data(idat[3][7:0]),
        .out_valid(ov_a[3]), .out_ready(ordy[3]), .out_result(res_a[3]), .out_slices(sl3), .busy(bsy_a[3]));

    // Walk the slices in order; bits at or beyond the operand width count as 1.
    task automatic ref_model(input int u, input logic [19:0] d, output bit res, output int n);
        int nsl;
        bit s;
        nsl = (dw_t[u] + sw_t[u] - 1) / sw_t[u];
        res = 1'b1;
        n = 0;
        for (int k = 0; k < nsl; k++) begin
            s = 1'b1;
            for (int b = 0; b < sw_t[u]; b++) begin
                int pos;
                pos = k * sw_t[u] + b;
                if (pos < dw_t[u] && d[pos] == 1'b0) s = 1'b0;
            end
            n = k + 1;
            if (!s) res = 1'b0;
            if (!s && ee_t[u] != 0) break;
        end
    endtask

    // Accept an operand, wait for the result, optionally stall in DONE, then drain.
    task automatic run_op(input string name, input int u, input logic [19:0] d, input int hold);
        bit eres;
        int en;
        int edges;
        logic r0;
        logic [2:0] s0;
        ref_model(u, d, eres, en);
        @(negedge clk);
        n_chk++;
        if (ir_a[u] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready_idle: got %b want 1", name, ir_a[u]);
        end
        iv[u] = 1'b1;
        idat[u] = d;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        iv[u] = 1'b0;
        idat[u] = 20'($urandom);
        while (ov_a[u] !== 1'b1 && edges < 40) begin
            n_chk++;
            if (bsy_a[u] !== 1'b1 || ir_a[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s eval_flags: busy=%b in_ready=%b want 1/0", name, bsy_a[u], ir_a[u]);
            end
            idat[u] = 20'($urandom);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        n_chk++;
        if (ov_a[u] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: out_valid never rose within %0d edges", name, edges);
        end else begin
            n_chk++;
            if (edges != en + 1) begin
                n_fail++;
                $display("FAIL %s latency: got %0d edges want %0d", name, edges, en + 1);
            end
            n_chk++;
            if (res_a[u] !== eres || sl_a[u] !== 3'(en)) begin
                n_fail++;
                $display("FAIL %s result: got res=%b slices=%0d want res=%b slices=%0d",
                         name, res_a[u], sl_a[u], eres, en);
            end
        end
        r0 = res_a[u];
        s0 = sl_a[u];
        for (int i = 0; i < hold; i++) begin
            iv[u] = 1'($urandom);
            idat[u] = 20'($urandom) & 20'h0FFFF;
            @(negedge clk);
            n_chk++;
            if (ov_a[u] !== 1'b1 || ir_a[u] !== 1'b0 || res_a[u] !== r0 || sl_a[u] !== s0) begin
                n_fail++;
                $display("FAIL %s hold: ov=%b ir=%b res=%b sl=%0d want ov=1 ir=0 res=%b sl=%0d",
                         name, ov_a[u], ir_a[u], res_a[u], sl_a[u], r0, s0);
            end
        end
        iv[u] = 1'b0;
        ordy[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[u] = 1'b0;
        n_chk++;
        if (ov_a[u] !== 1'b0 || ir_a[u] !== 1'b1 || bsy_a[u] !== 1'b0 ||
            res_a[u] !== eres || sl_a[u] !== 3'(en)) begin
            n_fail++;
            $display("FAIL %s drain: ov=%b ir=%b busy=%b res=%b sl=%0d want 0/1/0 res=%b sl=%0d",
                     name, ov_a[u], ir_a[u], bsy_a[u], res_a[u], sl_a[u], eres, en);
        end
        @(negedge clk);
        n_chk++;
        if (ov_a[u] !== 1'b0 || bsy_a[u] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ghost: ov=%b busy=%b after drain want 0/0", name, ov_a[u], bsy_a[u]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            n_chk++;
            if (ir_a[u] !== 1'b1 || ov_a[u] !== 1'b0 || res_a[u] !== 1'b0 ||
                sl_a[u] !== 3'd0 || bsy_a[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_u%0d: ir=%b ov=%b res=%b sl=%0d busy=%b want 1/0/0/0/0",
                         u, ir_a[u], ov_a[u], res_a[u], sl_a[u], bsy_a[u]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op("all_ones", 0, 20'hFFFFF, 0);
        run_op("early_exit", 0, 20'hFFEFF, 0);
        run_op("last_zero_ee", 0, 20'h0FFFF, 0);
        run_op("no_ee_mid", 1, 20'hFFEFF, 0);
        run_op("no_ee_last", 1, 20'h0FFFF, 0);
        run_op("pad_ones", 2, 20'h003FF, 0);
        run_op("pad_zero", 2, 20'h001FF, 0);
        run_op("nsl1_ones", 3, 20'h000FF, 0);
        run_op("nsl1_zero", 3, 20'h000FE, 0);
        run_op("first_zero", 0, 20'hFFFF0, 0);
    endtask

    task automatic test_done_hold();
        run_op("done_hold", 0, 20'hFFFFF, 4);
        run_op("done_hold_ee", 0, 20'hFFEFF, 3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int u;
            logic [19:0] d;
            u = int'($urandom_range(0, 3));
            d = 20'hFFFFF;
            if ($urandom_range(0, 3) != 0) d[$urandom_range(0, 19)] = 1'b0;
            if ($urandom_range(0, 3) == 0) d[$urandom_range(0, 19)] = 1'b0;
            run_op("random", u, d, int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        iv[0] = 1'b1;
        idat[0] = 20'hFFFFF;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (ov_a[0] !== 1'b0 || bsy_a[0] !== 1'b0 || ir_a[0] !== 1'b1 ||
            res_a[0] !== 1'b0 || sl_a[0] !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_abort: ov=%b busy=%b ir=%b res=%b sl=%0d want 0/0/1/0/0",
                     ov_a[0], bsy_a[0], ir_a[0], res_a[0], sl_a[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_abort", 0, 20'hFFFFF, 0);
    endtask

    initial begin
        for (int u = 0; u < 4; u++) idat[u] = '0;
        test_reset();
        test_directed();
        test_done_hold();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
